// File: rtl/freq_gate_ctrl_if.sv
// Control/result bundle between the CPU-side PIO block and the gate sequencer.
// master drives start/gate_len, slave returns status and latched counts.
interface freq_gate_ctrl_if;
    logic        start;
    logic [31:0] gate_len;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] count_sig;
    logic [31:0] count_ref;

    modport master (
        output start,
        output gate_len,
        input  busy,
        input  done,
        input  timeout,
        input  count_sig,
        input  count_ref
    );

    modport slave (
        input  start,
        input  gate_len,
        output busy,
        output done,
        output timeout,
        output count_sig,
        output count_ref
    );
endinterface

// File: rtl/freq_gate_ctrl.sv
// Gate sequencer for a reciprocal frequency meter: opens on a synchronised
// signal edge, closes on the first edge after gate_len clk cycles.
module freq_gate_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 50000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sig_in,
    freq_gate_ctrl_if.slave bus
);
    localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_MEAS,
        S_CLOSE,
        S_DONE,
        S_ABORT
    } state_e;

    state_e state_q, state_d;

    logic [NS-1:0] sync_q, sync_d;
    logic          sig_p_q, sig_p_d;
    logic          sig_s;
    logic          sig_rise;

    logic [31:0]   glen_q, glen_d;
    logic [31:0]   gate_tmr_q, gate_tmr_d;
    logic [31:0]   cnt_sig_q, cnt_sig_d;
    logic [31:0]   cnt_ref_q, cnt_ref_d;
    logic [31:0]   count_sig_q, count_sig_d;
    logic [31:0]   count_ref_q, count_ref_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;

    logic          tmo_hit;
    logic          gate_hit;
    logic          done_o;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Edge detection looks only at the last synchroniser stage.
    assign sync_d   = {sync_q[NS-2:0], sig_in};
    assign sig_s    = sync_q[NS-1];
    assign sig_p_d  = sig_s;
    assign sig_rise = sig_s & ~sig_p_q;

    assign tmo_hit  = (tmo_q == TMO_LAST);
    assign gate_hit = (gate_tmr_q == glen_q - 32'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_ARM;
            end
            S_ARM: begin
                if (sig_rise)     state_d = S_MEAS;
                else if (tmo_hit) state_d = S_ABORT;
            end
            S_MEAS: begin
                if (gate_hit) state_d = S_CLOSE;
            end
            S_CLOSE: begin
                if (sig_rise)     state_d = S_DONE;
                else if (tmo_hit) state_d = S_ABORT;
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done_o = (state_q == S_DONE);
    end

    always_comb begin
        glen_d      = glen_q;
        gate_tmr_d  = gate_tmr_q;
        cnt_sig_d   = cnt_sig_q;
        cnt_ref_d   = cnt_ref_q;
        count_sig_d = count_sig_q;
        count_ref_d = count_ref_q;
        tmo_d       = tmo_q;
        busy_d      = busy_q;
        timeout_d   = timeout_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    glen_d    = (bus.gate_len == 32'd0) ? 32'd1 : bus.gate_len;
                    busy_d    = 1'b1;
                    timeout_d = 1'b0;
                    tmo_d     = '0;
                end
            end
            S_ARM: begin
                // The opening edge itself is not counted.
                if (sig_rise) begin
                    cnt_sig_d  = 32'd0;
                    cnt_ref_d  = 32'd0;
                    gate_tmr_d = 32'd0;
                    tmo_d      = '0;
                end else if (!tmo_hit) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_MEAS: begin
                cnt_ref_d  = sat_inc(cnt_ref_q);
                gate_tmr_d = gate_tmr_q + 32'd1;
                if (sig_rise) cnt_sig_d = sat_inc(cnt_sig_q);
            end
            S_CLOSE: begin
                cnt_ref_d = sat_inc(cnt_ref_q);
                if (sig_rise) begin
                    cnt_sig_d   = sat_inc(cnt_sig_q);
                    count_sig_d = sat_inc(cnt_sig_q);
                    count_ref_d = sat_inc(cnt_ref_q);
                end else if (!tmo_hit) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
            end
            S_ABORT: begin
                count_sig_d = 32'd0;
                count_ref_d = 32'd0;
                timeout_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            sig_p_q     <= 1'b0;
            glen_q      <= 32'd1;
            gate_tmr_q  <= 32'd0;
            cnt_sig_q   <= 32'd0;
            cnt_ref_q   <= 32'd0;
            count_sig_q <= 32'd0;
            count_ref_q <= 32'd0;
            tmo_q       <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            sig_p_q     <= sig_p_d;
            glen_q      <= glen_d;
            gate_tmr_q  <= gate_tmr_d;
            cnt_sig_q   <= cnt_sig_d;
            cnt_ref_q   <= cnt_ref_d;
            count_sig_q <= count_sig_d;
            count_ref_q <= count_ref_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_o;
    assign bus.timeout   = timeout_q;
    assign bus.count_sig = count_sig_q;
    assign bus.count_ref = count_ref_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: vector table, corner sequences and random runs
// checked against an edge-timeline model of the gate rules.
module tb_freq_gate_ctrl;
    localparam int TMO  = 1000;
    localparam int SYNC = 2;

    typedef struct {
        logic [31:0] gl;
        int          per;
        bit          spam;
        int          ecs;
        int          ecr;
        bit          eto;
    } vec_t;

    logic clk;
    logic reset;
    logic sig_in;

    freq_gate_ctrl_if m();

    freq_gate_ctrl #(
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sig_in(sig_in),
        .bus   (m)
    );

    int   cyc      = 0;
    int   done_cnt = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   rq[$];
    logic sp       = 1'b0;
    int   gmode    = 0;
    int   per      = 10;
    int   ph       = 0;
    int   dwell    = 0;
    vec_t tab[9];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Timeline of synchronised rising edges: a source rise in cycle k
    // appears SYNC cycles later; reset flushes edges still in flight.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            while (rq.size() > 0 && rq[$] > cyc) void'(rq.pop_back());
            sp <= 1'b0;
        end else begin
            if (sig_in && !sp) rq.push_back(cyc + SYNC);
            sp <= sig_in;
        end
    end

    always @(posedge clk) begin
        if (m.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (gmode == 1) begin
                sig_in = (ph < per / 2);
                ph = (ph + 1 >= per) ? 0 : ph + 1;
            end else if (gmode == 2) begin
                if (dwell == 0) begin
                    sig_in = ~sig_in;
                    dwell = $urandom_range(0, per - 1);
                end else begin
                    dwell = dwell - 1;
                end
            end else begin
                sig_in = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_gen(input int md, input int p);
        @(negedge clk);
        gmode = md;
        per   = p;
        ph    = 0;
        dwell = 0;
        repeat (5) @(negedge clk);
    endtask

    // Expected outcome for a start in cycle a, from the edge timeline alone.
    function automatic void predict(input int a, input longint g,
                                    output int pd, output int pcs,
                                    output int pcr, output bit pto);
        longint o;
        longint e;
        o = -1;
        e = -1;
        pcs = 0;
        pcr = 0;
        pto = 1'b0;
        foreach (rq[i])
            if (o < 0 && rq[i] > a && rq[i] <= a + TMO) o = rq[i];
        if (o < 0) begin
            pto = 1'b1;
            pd = a + TMO + 2;
            return;
        end
        foreach (rq[i])
            if (e < 0 && rq[i] > o + g && rq[i] <= o + g + TMO) e = rq[i];
        if (e < 0) begin
            pto = 1'b1;
            pd = int'(o + g) + TMO + 2;
            return;
        end
        pd  = int'(e) + 1;
        pcr = int'(e - o);
        foreach (rq[i])
            if (rq[i] > o && rq[i] <= e) pcs++;
    endfunction

    task automatic run_meas(input logic [31:0] gl, input bit spam,
                            input bit use_tab, input int ecs, input int ecr,
                            input bit eto, input string nm);
        int          a;
        int          d;
        int          pd;
        int          pcs;
        int          pcr;
        int          bad;
        int          n0;
        int          bound;
        bit          pto;
        longint      ge;
        logic [31:0] cs;
        logic [31:0] cr;
        logic        to;
        ge    = (gl == 32'd0) ? 64'd1 : longint'(gl);
        bound = int'(ge) + 2 * TMO + 60;
        n0    = done_cnt;
        cs    = 'x;
        cr    = 'x;
        to    = 1'bx;
        @(posedge clk);
        #1;
        m.start    = 1'b1;
        m.gate_len = gl;
        a          = cyc;
        @(posedge clk);
        #1;
        m.start    = 1'b0;
        m.gate_len = $urandom;
        d   = -1;
        bad = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (i == 0) chk({nm, ":tmo_clr"}, 32'(m.timeout), 32'd0);
            if (m.done === 1'b1) begin
                d  = cyc;
                cs = m.count_sig;
                cr = m.count_ref;
                to = m.timeout;
                m.start = spam;
                break;
            end
            if (m.busy !== 1'b1) bad++;
            m.start = spam && (i % 5 == 1);
        end
        if (d < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s:no_done got none expected a pulse in %0d cycles",
                     nm, bound);
        end
        predict(a, ge, pd, pcs, pcr, pto);
        chk({nm, ":done_cyc"}, d, pd);
        if (use_tab) begin
            chk({nm, ":count_sig"}, cs, ecs);
            chk({nm, ":count_ref"}, cr, ecr);
            chk({nm, ":timeout"}, 32'(to), 32'(eto));
        end else begin
            chk({nm, ":count_sig"}, cs, pcs);
            chk({nm, ":count_ref"}, cr, pcr);
            chk({nm, ":timeout"}, 32'(to), 32'(pto));
        end
        chk({nm, ":busy_hold"}, bad, 0);
        @(negedge clk);
        m.start = 1'b0;
        chk({nm, ":busy_after"}, 32'(m.busy), 32'd0);
        chk({nm, ":done_width"}, 32'(m.done), 32'd0);
        repeat (3) @(negedge clk);
        chk({nm, ":done_count"}, done_cnt - n0, 1);
        chk({nm, ":idle_busy"}, 32'(m.busy), 32'd0);
    endtask

    initial begin
        int n0;
        tab[0] = '{32'd100, 10, 1'b0, 11, 110, 1'b0};
        tab[1] = '{32'd0,    8, 1'b0,  1,   8, 1'b0};
        tab[2] = '{32'd8,    8, 1'b0,  2,  16, 1'b0};
        tab[3] = '{32'd7,    8, 1'b0,  1,   8, 1'b0};
        tab[4] = '{32'd9,    8, 1'b0,  2,  16, 1'b0};
        tab[5] = '{32'd100,  0, 1'b0,  0,   0, 1'b1};
        tab[6] = '{32'd50,   6, 1'b0,  9,  54, 1'b0};
        tab[7] = '{32'd100, 10, 1'b1, 11, 110, 1'b0};
        tab[8] = '{32'd3,    2, 1'b0,  2,   4, 1'b0};

        reset      = 1'b1;
        m.start    = 1'b0;
        m.gate_len = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        set_gen(1, 10);
        repeat (100) @(negedge clk);
        chk("idle:done_count", done_cnt, 0);
        chk("idle:busy", 32'(m.busy), 32'd0);
        chk("idle:timeout", 32'(m.timeout), 32'd0);
        chk("idle:count_sig", m.count_sig, 32'd0);
        chk("idle:count_ref", m.count_ref, 32'd0);

        for (int i = 0; i < 9; i++) begin
            set_gen((tab[i].per == 0) ? 0 : 1, tab[i].per);
            run_meas(tab[i].gl, tab[i].spam, 1'b1, tab[i].ecs, tab[i].ecr,
                     tab[i].eto, $sformatf("vec%0d", i));
            if (tab[i].eto) begin
                repeat (20) @(negedge clk);
                chk($sformatf("vec%0d:tmo_hold", i), 32'(m.timeout), 32'd1);
            end
        end

        set_gen(1, 10);
        n0 = done_cnt;
        @(posedge clk);
        #1;
        m.start    = 1'b1;
        m.gate_len = 32'd100;
        @(posedge clk);
        #1;
        m.start = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst:busy", 32'(m.busy), 32'd0);
        chk("rst:count_sig", m.count_sig, 32'd0);
        chk("rst:count_ref", m.count_ref, 32'd0);
        chk("rst:timeout", 32'(m.timeout), 32'd0);
        repeat (150) @(negedge clk);
        chk("rst:no_done", done_cnt - n0, 0);
        chk("rst:count_held", m.count_ref, 32'd0);
        run_meas(32'd100, 1'b0, 1'b1, 11, 110, 1'b0, "after_rst");

        set_gen(1, 10);
        fork
            run_meas(32'd20, 1'b0, 1'b1, 0, 0, 1'b1, "close_tmo");
            begin
                repeat (26) @(posedge clk);
                #2;
                gmode = 0;
            end
        join

        for (int r = 0; r < 14; r++) begin
            if (r % 4 == 3) set_gen(0, 2);
            else set_gen(2, $urandom_range(1, 30));
            run_meas($urandom_range(0, 120), (r % 3 == 0), 1'b0, 0, 0, 1'b0,
                     $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/freq_gate_ctrl.md
Name: freq_gate_ctrl

Overview:
- Gate sequencer for the reciprocal (equal-precision) frequency meter.
- Synchronises the external signal and opens a measurement gate on a signal rising edge.
- Keeps the gate open for at least gate_len clk cycles, then closes it on the next signal rising edge.
- Latches signal-edge and reference-cycle counts into registers that feed the 32-bit PIO read ports (Freq_a / Freq_b) polled by the CPU; f_sig = f_clk * count_sig / count_ref.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the sig_in synchroniser (minimum 2).
- TIMEOUT_CYC, 50000000, clk cycles without a signal edge in ARM or CLOSE before the measurement aborts.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a measurement when idle.
- gate_len  in  32  minimum gate length in clk cycles; sampled on accepted start; 0 is treated as 1.
- sig_in  in  1  asynchronous signal under test.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse when results are updated.
- timeout  out  1  high if the last measurement aborted; held until the next accepted start.
- count_sig  out  32  signal rising edges counted inside the gate.
- count_ref  out  32  clk cycles inside the gate.

Behaviour:
- Reset (synchronous, active-high; fixed): the following return to their reset values.
  - State → IDLE.
  - All counters and the synchroniser → 0.
  - busy, done, timeout → 0.
  - count_sig, count_ref → 0.
  - Reset asserted mid-measurement aborts it with no done pulse.
- Edge detect: sig_rise is high for one cycle when the synchronised sig_in goes from 0 to 1. It is qualified by the synchroniser output only.
- States:
  - IDLE: start=1 → ARM. On that transition, latch gate_len (0 becomes 1), set busy=1, clear timeout, clear tmo_cnt. start outside IDLE is ignored.
  - ARM: sig_rise → MEAS; this is the opening edge and is not counted. Clear cnt_sig, cnt_ref, gate_tmr and tmo_cnt. Otherwise tmo_cnt+1; when tmo_cnt reaches TIMEOUT_CYC-1 → ABORT.
  - MEAS: every cycle cnt_ref+1 and gate_tmr+1. On sig_rise, cnt_sig+1. When gate_tmr equals gate_len-1 (checked before the increment) → CLOSE. That cycle's sig_rise is still counted.
  - CLOSE: every cycle cnt_ref+1. Without sig_rise, tmo_cnt+1; when tmo_cnt reaches TIMEOUT_CYC-1 → ABORT. On sig_rise (the closing edge), cnt_sig+1, then:
    - count_sig ← cnt_sig+1 and count_ref ← cnt_ref+1;
    - → DONE.
  - DONE: done=1 for exactly one cycle, busy→0, → IDLE.
  - ABORT: count_sig←0, count_ref←0, timeout←1, → DONE.
- Counter width rules:
  - cnt_ref and cnt_sig saturate at 0xFFFFFFFF; they do not wrap.
  - tmo_cnt is wide enough for TIMEOUT_CYC.
- Output hold: count_sig and count_ref hold their values until the next DONE. They are never visibly updated mid-measurement.
- Latency from the opening sig_rise: gate close ≥ gate_len cycles; done asserts one cycle after the closing-edge cycle.
- Simultaneous events:
  - In the cycle the gate timer expires, a sig_rise counts in MEAS and does not close the gate. Closure needs a later edge.
  - reset has priority over start and over everything else.

Test Plan:
- reset=1 for 3 cycles, then sig_in toggling every 5 clk with no start → count_sig=0, count_ref=0, busy=0, done never asserts.
- sig_in period 10 clk (rising edges aligned at synchroniser output), gate_len=100, start pulse → done pulse once; count_sig=11, count_ref=110, timeout=0; busy high from the cycle after start until done.
- gate_len=0, sig period 8 → treated as 1; gate closes on the edge after opening; count_sig=1, count_ref=8.
- sig_in held low, TIMEOUT_CYC=1000 (override), start → done pulse about 1000 cycles after start; timeout=1; counts=0. A second start with a toggling signal then clears timeout and returns valid counts.
- start pulsed repeatedly while busy, and again in the DONE cycle → ignored; only one measurement is performed, results as in the 100-cycle case.
- reset asserted midway through MEAS, start reissued → no done from the first run; the second run's results equal a clean run; outputs read 0 between reset and the second done.
